timer_irq: RTL and testbench

Memory-mapped 32-bit interval timer: the interrupt source on the IRQ input of the single-cycle MIPS control path. It sits on the data-memory bus beside RAM and decodes a three-word peripheral window. On counter overflow it reloads from a programmable value and raises a level interrupt. The interrupt is held until the kernel handler clears it by a store, because the CPU ignores IRQ while PC[31] is set.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_tick_gen.sv | 32 +++
 rtl/timer_irq.sv | 90 +++++++++
 tb/tb_timer_irq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register map,
// TCON bit positions, reset value and the peripheral-window address decoder.
package timer_pkg;

   localparam logic [31:0] TH_OFF   = 32'd0;
   localparam logic [31:0] TL_OFF   = 32'd4;
   localparam logic [31:0] TCON_OFF = 32'd8;

   localparam int TIM_EN = 0;
   localparam int IRQ_EN = 1;
   localparam int IRQ_ST = 2;
   localparam int OVR    = 3;

   localparam logic [3:0] TCON_RST = 4'h0;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_TH,
      SEL_TL,
      SEL_TCON
   } reg_sel_e;

   // Byte-lane bits are masked off so any byte address inside a word hits it.
   function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] base);
      logic [31:0] off;
      off = (addr & ~32'h3) - base;
      case (off)
         TH_OFF:   return SEL_TH;
         TL_OFF:   return SEL_TL;
         TCON_OFF: return SEL_TCON;
         default:  return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler: asserts tick once every PRESCALE enabled clocks, starting
// PRESCALE clocks after enable rises; held at zero while disabled.
module timer_tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] r_cnt;
   logic        w_last;

   assign w_last = (r_cnt == LAST);
   // NOTE: tick is decoded from the current count, not registered, so a tick
   // due in the same cycle that software clears tim_en is still applied.
   assign tick   = enable & w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!enable || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped 32-bit interval timer with reload, sticky overrun and a
// level interrupt that stays asserted until software clears irq_status.
module timer_irq
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        irqout
);

   logic [31:0] r_th;
   logic [31:0] r_tl;
   logic        r_tim_en;
   logic        r_irq_en;
   logic        r_irq_st;
   logic        r_ovr;

   reg_sel_e    w_sel;
   logic        w_wr_th, w_wr_tl, w_wr_tcon;
   logic        w_tick, w_ovf;
   logic        w_st_set, w_st_clr, w_ovr_set, w_ovr_clr;
   logic [31:0] w_tcon;

   timer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (r_tim_en),
      .tick   (w_tick)
   );

   assign w_sel     = decode_addr(Addr, BASE_ADDR);
   assign w_wr_th   = MemWrite & (w_sel == SEL_TH);
   assign w_wr_tl   = MemWrite & (w_sel == SEL_TL);
   assign w_wr_tcon = MemWrite & (w_sel == SEL_TCON);

   assign w_ovf     = w_tick & (r_tl == 32'hFFFF_FFFF);
   assign w_st_set  = w_ovf & r_irq_en;
   assign w_st_clr  = w_wr_tcon & ~WriteData[IRQ_ST];
   // An overflow that races a software clear of irq_status is not an overrun.
   assign w_ovr_set = w_st_set & r_irq_st & ~w_st_clr;
   assign w_ovr_clr = w_wr_tcon & ~WriteData[OVR];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_th <= '0;
         r_tl <= '0;
         {r_ovr, r_irq_st, r_irq_en, r_tim_en} <= TCON_RST;
      end else begin
         if (w_wr_th) r_th <= WriteData;

         if (w_wr_tl)     r_tl <= WriteData;
         else if (w_tick) r_tl <= w_ovf ? r_th : r_tl + 32'd1;

         if (w_wr_tcon) begin
            r_tim_en <= WriteData[TIM_EN];
            r_irq_en <= WriteData[IRQ_EN];
         end

         if (w_st_set)      r_irq_st <= 1'b1;
         else if (w_st_clr) r_irq_st <= 1'b0;

         if (w_ovr_set)      r_ovr <= 1'b1;
         else if (w_ovr_clr) r_ovr <= 1'b0;
      end
   end

   assign w_tcon = {28'd0, r_ovr, r_irq_st, r_irq_en, r_tim_en};
   assign irqout = r_irq_en & r_irq_st;

   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         case (w_sel)
            SEL_TH:   ReadData = r_th;
            SEL_TL:   ReadData = r_tl;
            SEL_TCON: ReadData = w_tcon;
            default:  ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_irq.sv
// Randomized and directed bench for timer_irq, running PRESCALE=1 and
// PRESCALE=3 instances side by side against a register-level model.
module tb_timer_irq;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH   = BASE;
   localparam logic [31:0] A_TL   = BASE + 32'd4;
   localparam logic [31:0] A_TCON = BASE + 32'd8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] Addr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] rd1, rd3;
   logic        irq1, irq3;

   int n_vec = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   timer_irq #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Addr(Addr), .WriteData(WriteData), .ReadData(rd1), .irqout(irq1));

   timer_irq #(.BASE_ADDR(BASE), .PRESCALE(3)) dut3 (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Addr(Addr), .WriteData(WriteData), .ReadData(rd3), .irqout(irq3));

   // Model state: register contents plus elapsed enabled clocks modulo PRESCALE.
   typedef struct {
      logic [31:0] th;
      logic [31:0] tl;
      logic        en;
      logic        ie;
      logic        st;
      logic        ovr;
      int          phase;
   } mdl_t;

   mdl_t m [2];
   int   pre [2] = '{1, 3};

   function automatic mdl_t mdl_reset();
      mdl_t z;
      z.th = '0; z.tl = '0; z.en = 1'b0; z.ie = 1'b0;
      z.st = 1'b0; z.ovr = 1'b0; z.phase = 0;
      return z;
   endfunction

   function automatic logic [31:0] word_off(input logic [31:0] a);
      return (a & ~32'h3) - BASE;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input int p, input logic wr,
                                     input logic [31:0] a, input logic [31:0] wd);
      mdl_t        n;
      logic [31:0] off;
      logic        tick, ovf, set_st, clr_st, set_ovr;
      n       = s;
      off     = word_off(a);
      tick    = s.en && (((s.phase + 1) % p) == 0);
      ovf     = tick && (s.tl == 32'hFFFF_FFFF);
      set_st  = ovf && s.ie;
      clr_st  = wr && (off == 32'd8) && !wd[2];
      set_ovr = set_st && s.st && !clr_st;
      n.phase = s.en ? (s.phase + 1) % p : 0;
      if (tick) n.tl = ovf ? s.th : s.tl + 32'd1;
      if (wr && off == 32'd0) n.th = wd;
      if (wr && off == 32'd4) n.tl = wd;
      if (wr && off == 32'd8) begin
         n.en = wd[0];
         n.ie = wd[1];
         if (!wd[3]) n.ovr = 1'b0;
      end
      if (clr_st) n.st = 1'b0;
      if (set_st) n.st = 1'b1;
      if (set_ovr) n.ovr = 1'b1;
      return n;
   endfunction

   function automatic logic [31:0] mdl_read(input mdl_t s, input logic rd,
                                            input logic [31:0] a);
      if (!rd) return 32'd0;
      case (word_off(a))
         32'd0:   return s.th;
         32'd4:   return s.tl;
         32'd8:   return {28'd0, s.ovr, s.st, s.ie, s.en};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) m[i] = mdl_reset();
         else       m[i] = mdl_step(m[i], pre[i], MemWrite, Addr, WriteData);
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("rd_p1",  rd1, mdl_read(m[0], MemRead, Addr));
      check("irq_p1", {31'd0, irq1}, {31'd0, m[0].ie & m[0].st});
      check("rd_p3",  rd3, mdl_read(m[1], MemRead, Addr));
      check("irq_p3", {31'd0, irq3}, {31'd0, m[1].ie & m[1].st});
   end

   task automatic wait_cycles(input int n);
      MemWrite = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Addr      = a;
      WriteData = d;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      MemRead = 1'b1;
      Addr    = a;
      #1;
   endtask

   task automatic rand_cycle();
      int          sel;
      logic [31:0] a;
      sel = $urandom_range(0, 5);
      case (sel)
         0: a = A_TH;
         1: a = A_TL;
         2: a = A_TCON;
         3: a = BASE + 32'd12;
         4: a = BASE + 32'd16 + 32'($urandom_range(0, 255));
         default: a = $urandom;
      endcase
      a = a | 32'($urandom_range(0, 3));
      Addr      = a;
      MemRead   = 1'($urandom_range(0, 1));
      MemWrite  = ($urandom_range(0, 3) == 0);
      WriteData = ($urandom_range(0, 3) != 0) ?
                  (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #1;

      // Reset state
      bus_read(A_TH);   check("rst_th",   rd1, 32'h0);
      bus_read(A_TL);   check("rst_tl",   rd1, 32'h0);
      bus_read(A_TCON); check("rst_tcon", rd1, 32'h0);

      // Basic overflow with PRESCALE=1
      bus_write(A_TH, 32'hFFFF_FFFC);
      bus_write(A_TL, 32'hFFFF_FFFC);
      bus_read(A_TL);   check("tl_init", rd1, 32'hFFFF_FFFC);
      bus_write(A_TCON, 32'h3);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         check("irq_rise", {31'd0, irq1}, (i == 4) ? 32'd1 : 32'd0);
      end
      bus_read(A_TL);   check("tl_reload", rd1, 32'hFFFF_FFFC);

      // Second unserviced overflow sets ovr
      wait_cycles(4);
      bus_read(A_TCON); check("tcon_ovr", rd1, 32'hF);
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON); check("tcon_clr", rd1, 32'h3);
      check("irq_clr", {31'd0, irq1}, 32'd0);

      // Clear of irq_status on the overflow edge: the set wins
      wait_cycles(6);
      bus_write(A_TCON, 32'h3);
      bus_read(A_TCON); check("clr_vs_ovf", rd1, 32'h7);
      check("irq_held", {31'd0, irq1}, 32'd1);

      // TL write on the overflow edge: the write wins
      wait_cycles(3);
      bus_write(A_TL, 32'h1234_5678);
      bus_read(A_TL);   check("tl_wr_wins", rd1, 32'h1234_5678);
      bus_write(A_TCON, 32'h0);

      // Prescaler with PRESCALE=3
      bus_write(A_TL, 32'h0);
      bus_write(A_TCON, 32'h1);
      wait_cycles(2); bus_read(A_TL); check("pre_t2", rd3, 32'd0);
      wait_cycles(1); bus_read(A_TL); check("pre_t3", rd3, 32'd1);
      wait_cycles(3); bus_read(A_TL); check("pre_t6", rd3, 32'd2);
      bus_write(A_TCON, 32'h0);
      wait_cycles(6); bus_read(A_TL); check("pre_frozen", rd3, 32'd2);

      // Out-of-window write and gated read
      bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
      bus_read(A_TH);   check("dec_th",   rd3, 32'hFFFF_FFFC);
      bus_read(A_TL);   check("dec_tl",   rd3, 32'd2);
      bus_read(A_TCON); check("dec_tcon", rd3, 32'd0);
      MemRead = 1'b0; Addr = A_TH; #1;
      check("rd_gated", rd3, 32'd0);

      // Overflow with irq_en=0 leaves status untouched
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TCON, 32'h1);
      wait_cycles(2);
      check("noie_irq", {31'd0, irq1}, 32'd0);
      bus_read(A_TCON); check("noie_tcon", rd1, 32'h1);
      bus_write(A_TCON, 32'h0);

      // Asynchronous reset mid-count with TCON=F
      bus_write(A_TH, 32'hFFFF_FFFE);
      bus_write(A_TL, 32'hFFFF_FFFE);
      bus_write(A_TCON, 32'h3);
      wait_cycles(4);
      bus_read(A_TCON); check("pre_rst_tcon", rd1, 32'hF);
      #1 reset = 1'b1;
      #1;
      check("arst_tcon", rd1, 32'h0);
      check("arst_irq",  {31'd0, irq1}, 32'd0);
      Addr = A_TL; #1;
      check("arst_tl", rd1, 32'h0);
      @(negedge clk); #2 reset = 1'b0;
      wait_cycles(3);
      bus_read(A_TL);   check("post_rst_tl",   rd1, 32'h0);
      bus_read(A_TCON); check("post_rst_tcon", rd1, 32'h0);

      // Randomized traffic checked cycle by cycle against the model
      repeat (3000) rand_cycle();
      MemRead = 1'b0; MemWrite = 1'b0;
      wait_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
